// File: rtl/ar_seq_pkg.sv
// Shared state encoding and AR boundary constants for the AR block-transfer sequencer.
package ar_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    STEP,
    DONE,
    ALARM
  } state_t;

  localparam logic [15:0] AR_MAX = 16'hffff;
  localparam logic [15:0] AR_MIN = 16'h0000;

endpackage

// File: rtl/ar_seq_tmo.sv
// Timeout counter for the memory request: cleared on clr, counts while run,
// saturates at TIMEOUT-1 and flags expired there.
module ar_seq_tmo #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_sys,
  input  logic rst_,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmr;

  always_ff @(posedge clk_sys or negedge rst_) begin
    if (!rst_) begin
      tmr <= '0;
    end else if (clr) begin
      tmr <= '0;
    end else if (run && (tmr != TLAST)) begin
      tmr <= tmr + TW'(1);
    end
  end

  assign expired = (tmr == TLAST);

endmodule

// File: rtl/ar_seq.sv
// AR sequencer: loads AR, issues one memory request per word and steps AR
// between words, finishing with a done or alarm pulse.
module ar_seq
  import ar_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk_sys,
  input  logic             rst_,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] cnt,
  input  logic [15:0]      ar,
  input  logic             mok,
  input  logic             abort,
  output logic             ar_ld,
  output logic             ar_inc,
  output logic             ar_dec,
  output logic             mreq,
  output logic             busy,
  output logic             done,
  output logic             alarm
);

  state_t           state, nxt;
  logic [CNT_W-1:0] rem;
  logic             dir_q;
  logic             wrap_q;
  logic             expired;
  logic             step_ok;

  ar_seq_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_sys (clk_sys),
    .rst_    (rst_),
    .clr     ((state == LOAD) || (state == STEP)),
    .run     (state == REQ),
    .expired (expired)
  );

  always_ff @(posedge clk_sys or negedge rst_) begin
    if (!rst_) begin
      state  <= IDLE;
      rem    <= '0;
      dir_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state <= nxt;
      if ((state == IDLE) && start) begin
        rem   <= cnt;
        dir_q <= dir;
      end
      if ((state == STEP) && (rem != '0)) begin
        rem <= rem - CNT_W'(1);
      end
      // Wrap is judged on the address of the request in flight and held
      // into STEP, so the step strobe stays a pure function of registers.
      if (state == REQ) begin
        wrap_q <= dir_q ? (ar == AR_MIN) : (ar == AR_MAX);
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = (cnt != '0) ? LOAD : DONE;
      LOAD:  nxt = abort ? IDLE : REQ;
      REQ: begin
        if (abort)        nxt = IDLE;
        else if (mok)     nxt = STEP;
        else if (expired) nxt = ALARM;
      end
      STEP: begin
        if (abort)                    nxt = IDLE;
        else if (rem == CNT_W'(1))    nxt = DONE;
        else if (wrap_q)              nxt = ALARM;
        else                          nxt = REQ;
      end
      DONE:    nxt = IDLE;
      ALARM:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign step_ok = (state == STEP) && (rem != CNT_W'(1)) && !wrap_q;

  assign ar_ld  = (state == LOAD);
  assign ar_inc = step_ok && !dir_q;
  assign ar_dec = step_ok && dir_q;
  assign mreq   = (state == REQ);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign alarm  = (state == ALARM);

endmodule

// File: tb/tb_ar_seq.sv
// Bench for ar_seq: models the AR register and a memory responder, and checks
// each transfer against per-word expectations derived from the transfer rules.
module tb_ar_seq;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 16;

  logic             clk_sys = 1'b0;
  logic             rst_    = 1'b0;
  logic             start   = 1'b0;
  logic             dir     = 1'b0;
  logic [CNT_W-1:0] cnt     = '0;
  logic             mok     = 1'b0;
  logic             abort   = 1'b0;
  logic [15:0]      w_bus   = '0;
  logic [15:0]      ar_reg;
  logic ar_ld, ar_inc, ar_dec, mreq, busy, done, alarm;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  ar_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys (clk_sys),
    .rst_    (rst_),
    .start   (start),
    .dir     (dir),
    .cnt     (cnt),
    .ar      (ar_reg),
    .mok     (mok),
    .abort   (abort),
    .ar_ld   (ar_ld),
    .ar_inc  (ar_inc),
    .ar_dec  (ar_dec),
    .mreq    (mreq),
    .busy    (busy),
    .done    (done),
    .alarm   (alarm)
  );

  always @(posedge clk_sys or negedge rst_) begin
    if (!rst_)       ar_reg <= '0;
    else if (ar_ld)  ar_reg <= w_bus;
    else if (ar_inc) ar_reg <= ar_reg + 16'd1;
    else if (ar_dec) ar_reg <= ar_reg - 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one transfer; mok answers lat cycles after mreq rises (lat>=TIMEOUT: never in time).
  task automatic run_xfer(input logic [15:0] w, input logic [15:0] c, input logic d, input int lat);
    int n_ld = 0, n_inc = 0, n_dec = 0, n_req = 0, n_done = 0, n_alarm = 0;
    int busy_cyc = 0, req_cyc = 0, excl = 0, ld_at = -1, req_at = -1, hold = 0, idx;
    logic prev_mreq = 1'b0;
    logic [15:0] ar0;
    int e_ld = 0, e_inc = 0, e_dec = 0, e_nreq = 0, e_reqc = 0, e_busy = 0, nw = 0, addr;
    logic e_done = 1'b0, e_alarm = 1'b0;
    logic [15:0] e_ar;
    string t;

    ar0 = ar_reg;
    if (c == 0) begin
      e_done = 1'b1; e_ar = ar0; e_busy = 1;
    end else if (lat >= int'(TIMEOUT)) begin
      e_ld = 1; e_nreq = 1; e_reqc = TIMEOUT; e_alarm = 1'b1; e_ar = w; e_busy = TIMEOUT + 2;
    end else begin
      e_ld = 1;
      e_ar = w;
      for (int k = 0; k < int'(c); k++) begin
        addr = d ? int'(w) - k : int'(w) + k;
        e_ar = 16'(addr);
        nw = k + 1;
        if (k == int'(c) - 1) begin e_done = 1'b1; break; end
        if ((!d && addr == 65535) || (d && addr == 0)) begin e_alarm = 1'b1; break; end
        if (d) e_dec++; else e_inc++;
      end
      e_nreq = nw; e_reqc = nw * (lat + 1); e_busy = 2 + nw * (lat + 2);
    end

    w_bus = w; cnt = c; dir = d; start = 1'b1; mok = 1'b0;
    @(posedge clk_sys); #1;
    start = 1'b0;
    idx = 1;
    for (int i = 0; i < 4000; i++) begin
      if (busy) busy_cyc++;
      if (ar_ld)  begin n_ld++;  if (ld_at < 0) ld_at = idx; end
      if (ar_inc) n_inc++;
      if (ar_dec) n_dec++;
      if (done)   n_done++;
      if (alarm)  n_alarm++;
      if ((int'(ar_ld) + int'(ar_inc) + int'(ar_dec) > 1) || (done && alarm)) excl++;
      if (mreq) begin
        if (!prev_mreq) begin n_req++; if (req_at < 0) req_at = idx; end
        mok = (hold == lat);
        hold++;
        req_cyc++;
      end else begin
        mok = 1'b0;
        hold = 0;
      end
      prev_mreq = mreq;
      if (!busy) break;
      @(posedge clk_sys); #1;
      idx++;
    end
    mok = 1'b0;

    t = $sformatf("w%04h_c%0d_d%0d_l%0d", w, c, d, lat);
    chk({t, " stuck_busy"}, busy, 0);
    chk({t, " ld"}, n_ld, e_ld);
    chk({t, " inc"}, n_inc, e_inc);
    chk({t, " dec"}, n_dec, e_dec);
    chk({t, " mreq_n"}, n_req, e_nreq);
    chk({t, " mreq_cyc"}, req_cyc, e_reqc);
    chk({t, " done"}, n_done, e_done);
    chk({t, " alarm"}, n_alarm, e_alarm);
    chk({t, " ar"}, ar_reg, e_ar);
    chk({t, " busy_cyc"}, busy_cyc, e_busy);
    chk({t, " excl"}, excl, 0);
    if (c != 0) begin
      chk({t, " ld_at"}, ld_at, 1);
      chk({t, " req_at"}, req_at, 2);
    end
  endtask

  initial begin
    logic [15:0] w;
    int lat, acc;

    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_outs", {ar_ld, ar_inc, ar_dec, mreq, busy, done, alarm}, 0);
    rst_ = 1'b1;
    @(posedge clk_sys); #1;

    run_xfer(16'h1000, 3, 1'b0, 1);
    run_xfer(16'hbeef, 2, 1'b1, 1);
    run_xfer(16'h4321, 0, 1'b0, 0);
    run_xfer(16'h2000, 2, 1'b0, 255);
    run_xfer(16'h2000, 2, 1'b0, TIMEOUT - 1);
    run_xfer(16'hffff, 2, 1'b0, 1);
    run_xfer(16'h0000, 3, 1'b1, 0);
    run_xfer(16'hfffe, 2, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       w = 16'hffff - 16'($urandom_range(0, 3));
        1:       w = 16'($urandom_range(0, 3));
        default: w = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       lat = TIMEOUT - 1;
        1:       lat = TIMEOUT;
        2:       lat = 255;
        default: lat = $urandom_range(0, 4);
      endcase
      run_xfer(w, 16'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), lat);
    end

    // abort while a request is outstanding
    w_bus = 16'h3000; cnt = 3; dir = 1'b0; start = 1'b1;
    @(posedge clk_sys); #1; start = 1'b0;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    chk("abort_pre_mreq", mreq, 1);
    abort = 1'b1;
    @(posedge clk_sys); #1;
    abort = 1'b0;
    chk("abort_mreq", mreq, 0);
    chk("abort_busy", busy, 0);
    acc = 0;
    repeat (3) begin
      acc += int'(done) + int'(alarm) + int'(busy);
      @(posedge clk_sys); #1;
    end
    chk("abort_quiet", acc, 0);
    run_xfer(16'h3100, 2, 1'b1, 0);

    // asynchronous reset mid-transfer
    w_bus = 16'h5000; cnt = 4; dir = 1'b0; start = 1'b1;
    @(posedge clk_sys); #1; start = 1'b0;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    chk("rst_pre_busy", busy, 1);
    rst_ = 1'b0;
    #1;
    chk("rst_async_outs", {ar_ld, ar_inc, ar_dec, mreq, busy, done, alarm}, 0);
    @(posedge clk_sys); #1;
    rst_ = 1'b1;
    @(posedge clk_sys); #1;
    run_xfer(16'h0100, 2, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
